// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter for a CPU bridge (port 0) and DMA (port 1) onto one SDRAM controller; command is issued the cycle after grant.
// Requesters stall on mN_waitreq until acceptance; reads also stall while MAX_PEND reads await data, which returns in issue order.
module sdram_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_push,
  input  logic i_push_dat,
  input  logic i_pop,
  output logic o_head_dat,
  output logic o_empty,
  output logic o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_head_dat = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end
endmodule

module sdram_port_arbiter #(
  parameter int MAX_PEND = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [21:0] m0_addr,
  input  logic [21:0] m1_addr,
  input  logic [1:0]  m0_be_n,
  input  logic [1:0]  m1_be_n,
  input  logic [15:0] m0_wdata,
  input  logic [15:0] m1_wdata,
  input  logic        m0_rd_n,
  input  logic        m1_rd_n,
  input  logic        m0_wr_n,
  input  logic        m1_wr_n,
  output logic        m0_waitreq,
  output logic        m1_waitreq,
  output logic [15:0] m0_rdata,
  output logic [15:0] m1_rdata,
  output logic        m0_valid,
  output logic        m1_valid,
  output logic [21:0] az_addr,
  output logic [1:0]  az_be_n,
  output logic [15:0] az_data,
  output logic        az_rd_n,
  output logic        az_wr_n,
  input  logic [15:0] za_data,
  input  logic        za_valid,
  input  logic        za_waitrequest,
  output logic        proto_err
);
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;
  logic        r_last;
  logic        r_is_wr;
  logic [21:0] r_az_addr;
  logic [1:0]  r_az_be_n;
  logic [15:0] r_az_data;
  logic        r_az_rd_n;
  logic        r_az_wr_n;
  logic        r_m0_valid;
  logic        r_m1_valid;
  logic [15:0] r_m0_rdata;
  logic [15:0] r_m1_rdata;
  logic        r_proto_err;

  logic w_req0, w_req1, w_wr0, w_wr1, w_elig0, w_elig1;
  logic w_pick, w_pick_wr, w_grant_go, w_gnt_req;
  logic w_accept, w_m0_waitreq, w_m1_waitreq;
  logic w_push, w_pop, w_head, w_empty, w_full;

  // Both strobes low counts as a write; reads wait for a free tag slot.
  assign w_req0     = !m0_rd_n || !m0_wr_n;
  assign w_req1     = !m1_rd_n || !m1_wr_n;
  assign w_wr0      = !m0_wr_n;
  assign w_wr1      = !m1_wr_n;
  assign w_elig0    = w_req0 && (w_wr0 || !w_full);
  assign w_elig1    = w_req1 && (w_wr1 || !w_full);
  assign w_pick     = (w_elig0 && w_elig1) ? !r_last : w_elig1;
  assign w_pick_wr  = w_pick ? w_wr1 : w_wr0;
  assign w_grant_go = (r_state == IDLE) && (w_elig0 || w_elig1);
  assign w_gnt_req  = r_grant ? w_req1 : w_req0;
  assign w_push     = w_accept && !r_is_wr;
  assign w_pop      = za_valid && !w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_elig0 || w_elig1) w_state_nxt = ISSUE;
      ISSUE:   if (!za_waitrequest) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept     = 1'b0;
    w_m0_waitreq = 1'b1;
    w_m1_waitreq = 1'b1;
    if (r_state == ISSUE && !za_waitrequest) begin
      w_accept = 1'b1;
      if (r_grant) w_m1_waitreq = 1'b0;
      else         w_m0_waitreq = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_is_wr     <= 1'b0;
      r_az_addr   <= '0;
      r_az_be_n   <= 2'b11;
      r_az_data   <= '0;
      r_az_rd_n   <= 1'b1;
      r_az_wr_n   <= 1'b1;
      r_m0_valid  <= 1'b0;
      r_m1_valid  <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_grant_go) begin
        r_grant   <= w_pick;
        r_is_wr   <= w_pick_wr;
        r_az_addr <= w_pick ? m1_addr : m0_addr;
        r_az_be_n <= w_pick ? m1_be_n : m0_be_n;
        r_az_data <= w_pick ? m1_wdata : m0_wdata;
        r_az_rd_n <= w_pick_wr;
        r_az_wr_n <= !w_pick_wr;
      end else if (w_accept) begin
        r_az_rd_n <= 1'b1;
        r_az_wr_n <= 1'b1;
        r_last    <= r_grant;
      end
      r_m0_valid <= w_pop && !w_head;
      r_m1_valid <= w_pop && w_head;
      if (w_pop && !w_head) r_m0_rdata <= za_data;
      if (w_pop && w_head)  r_m1_rdata <= za_data;
      // Orphan return data or a requester abandoning an in-flight command.
      if ((za_valid && w_empty) || (r_state == ISSUE && !w_gnt_req)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  sdram_tag_fifo #(.DEPTH(MAX_PEND)) u_tag_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_push_dat (r_grant),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  assign m0_waitreq = w_m0_waitreq;
  assign m1_waitreq = w_m1_waitreq;
  assign m0_rdata   = r_m0_rdata;
  assign m1_rdata   = r_m1_rdata;
  assign m0_valid   = r_m0_valid;
  assign m1_valid   = r_m1_valid;
  assign az_addr    = r_az_addr;
  assign az_be_n    = r_az_be_n;
  assign az_data    = r_az_data;
  assign az_rd_n    = r_az_rd_n;
  assign az_wr_n    = r_az_wr_n;
  assign proto_err  = r_proto_err;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized two-master traffic against a transaction-level model.
module tb_sdram_port_arbiter;
  localparam int MAX_PEND = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [21:0] m0_addr = '0, m1_addr = '0;
  logic [1:0]  m0_be_n = 2'b11, m1_be_n = 2'b11;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_rd_n = 1'b1, m1_rd_n = 1'b1, m0_wr_n = 1'b1, m1_wr_n = 1'b1;
  logic        m0_waitreq, m1_waitreq, m0_valid, m1_valid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic [15:0] az_data;
  logic        az_rd_n, az_wr_n;
  logic [15:0] za_data = '0;
  logic        za_valid = 1'b0, za_waitrequest = 1'b0;
  logic        proto_err;

  sdram_port_arbiter #(.MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_be_n(m0_be_n), .m1_be_n(m1_be_n),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_rd_n(m0_rd_n), .m1_rd_n(m1_rd_n),
    .m0_wr_n(m0_wr_n), .m1_wr_n(m1_wr_n), .m0_waitreq(m0_waitreq), .m1_waitreq(m1_waitreq),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_valid(m0_valid), .m1_valid(m1_valid),
    .az_addr(az_addr), .az_be_n(az_be_n), .az_data(az_data), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n),
    .za_data(za_data), .za_valid(za_valid), .za_waitrequest(za_waitrequest), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  // Master-side transaction held on each port until that port sees waitreq low.
  bit          act[2];
  bit          wr[2];
  bit          both[2];
  logic [21:0] t_addr[2];
  logic [1:0]  t_be[2];
  logic [15:0] t_dat[2];
  bit          acc[2];
  // Controller-side stimulus for the next cycle; n_zv is one-shot.
  bit          n_wait = 1'b0;
  bit          n_zv = 1'b0;
  logic [15:0] n_zd = '0;
  // Ports of reads accepted and not yet answered, oldest first.
  int          rd_q[$];
  bit          ret_vld = 1'b0;
  int          ret_port = 0;
  logic [15:0] ret_dat = '0;
  bit          exp_vld;
  int          exp_port;
  logic [15:0] exp_dat;

  task automatic load(input int p, input bit w, input bit b);
    act[p]    = 1'b1;
    wr[p]     = w;
    both[p]   = b;
    t_addr[p] = 22'($urandom);
    t_be[p]   = 2'($urandom);
    t_dat[p]  = 16'($urandom);
  endtask

  // One clock: drive just after the rising edge, observe at the falling edge.
  task automatic cycle();
    @(posedge clk); #1;
    m0_rd_n  = !(act[0] && (!wr[0] || both[0]));
    m0_wr_n  = !(act[0] && wr[0]);
    m1_rd_n  = !(act[1] && (!wr[1] || both[1]));
    m1_wr_n  = !(act[1] && wr[1]);
    m0_addr  = t_addr[0]; m0_be_n = t_be[0]; m0_wdata = t_dat[0];
    m1_addr  = t_addr[1]; m1_be_n = t_be[1]; m1_wdata = t_dat[1];
    za_waitrequest = n_wait;
    za_valid = n_zv;
    za_data  = n_zd;
    exp_vld  = ret_vld; exp_port = ret_port; exp_dat = ret_dat;
    ret_vld  = 1'b0;
    if (n_zv && rd_q.size() > 0) begin
      ret_vld  = 1'b1;
      ret_port = rd_q.pop_front();
      ret_dat  = n_zd;
    end
    n_zv = 1'b0;
    @(negedge clk);
    acc[0] = !m0_waitreq;
    acc[1] = !m1_waitreq;
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        act[p] = 1'b0;
        if (!wr[p]) rd_q.push_back(p);
      end
    end
  endtask

  task automatic test_reset();
    act = '{default: 1'b0};
    n_wait = 1'b0; n_zv = 1'b0; ret_vld = 1'b0;
    rd_q.delete();
    @(posedge clk); #2;
    reset_n = 1'b0;
    cycle();
    checks++;
    if ({az_rd_n, az_wr_n, az_addr, az_be_n, az_data, m0_valid, m1_valid, m0_rdata, m1_rdata,
         proto_err, m0_waitreq, m1_waitreq} !==
        {1'b1, 1'b1, 22'd0, 2'b11, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got rd_n=%b wr_n=%b addr=%h be_n=%b data=%h v=%b%b rd=%h/%h err=%b wq=%b%b want 1 1 0 11 0 00 0/0 0 11",
               az_rd_n, az_wr_n, az_addr, az_be_n, az_data, m0_valid, m1_valid, m0_rdata, m1_rdata,
               proto_err, m0_waitreq, m1_waitreq);
    end
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    test_reset();
    load(0, 1'b0, 1'b0);
    t_addr[0] = 22'h000100;
    cycle();
    checks++;
    if (az_rd_n !== 1'b1 || m0_waitreq !== 1'b1) begin
      errors++; $display("FAIL sr_idle: az_rd_n=%b m0_waitreq=%b want 1 1", az_rd_n, m0_waitreq);
    end
    cycle();
    checks++;
    if (az_rd_n !== 1'b0 || az_wr_n !== 1'b1 || az_addr !== 22'h000100 || az_be_n !== t_be[0] ||
        m0_waitreq !== 1'b0 || m1_waitreq !== 1'b1) begin
      errors++;
      $display("FAIL sr_issue: rd_n=%b wr_n=%b addr=%h be=%b wq0=%b wq1=%b want 0 1 000100 %b 0 1",
               az_rd_n, az_wr_n, az_addr, az_be_n, m0_waitreq, m1_waitreq, t_be[0]);
    end
    cycle();
    checks++;
    if (az_rd_n !== 1'b1) begin errors++; $display("FAIL sr_one_cycle: az_rd_n=%b want 1", az_rd_n); end
    n_zv = 1'b1; n_zd = 16'hBEEF;
    cycle();
    checks++;
    if (m0_valid !== 1'b0 || m1_valid !== 1'b0) begin
      errors++; $display("FAIL sr_early: valid=%b%b want 00", m0_valid, m1_valid);
    end
    cycle();
    checks++;
    if (m0_valid !== 1'b1 || m0_rdata !== 16'hBEEF || m1_valid !== 1'b0) begin
      errors++; $display("FAIL sr_strobe: m0_valid=%b m0_rdata=%h m1_valid=%b want 1 beef 0", m0_valid, m0_rdata, m1_valid);
    end
    cycle();
    checks++;
    if (m0_valid !== 1'b0 || m0_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL sr_pulse_end: m0_valid=%b m0_rdata=%h want 0 beef", m0_valid, m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    int seq[$];
    int at[$];
    test_reset();
    load(0, 1'b1, 1'b0);
    load(1, 1'b1, 1'b0);
    for (int c = 0; c < 40 && seq.size() < 8; c++) begin
      cycle();
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          checks++;
          if (az_wr_n !== 1'b0 || az_rd_n !== 1'b1 || az_addr !== t_addr[p] ||
              az_data !== t_dat[p] || az_be_n !== t_be[p]) begin
            errors++;
            $display("FAIL rr_payload: port %0d got wr_n=%b addr=%h data=%h be=%b want 0 %h %h %b",
                     p, az_wr_n, az_addr, az_data, az_be_n, t_addr[p], t_dat[p], t_be[p]);
          end
          seq.push_back(p);
          at.push_back(c);
          if (seq.size() < 8) load(p, 1'b1, 1'b0);
        end
      end
    end
    checks++;
    if (seq.size() != 8) begin errors++; $display("FAIL rr_count: got %0d grants want 8", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] != i % 2) begin errors++; $display("FAIL rr_order: grant %0d went to port %0d want %0d", i, seq[i], i % 2); end
      if (i > 0) begin
        checks++;
        if (at[i] - at[i-1] != 2) begin
          errors++; $display("FAIL rr_rate: gap before grant %0d is %0d cycles want 2", i, at[i] - at[i-1]);
        end
      end
    end
  endtask

  task automatic test_wait_stall();
    test_reset();
    load(1, 1'b1, 1'b0);
    n_wait = 1'b1;
    cycle();
    for (int c = 1; c <= 5; c++) begin
      cycle();
      checks++;
      if (az_wr_n !== 1'b0 || az_rd_n !== 1'b1 || az_addr !== t_addr[1] || az_data !== t_dat[1] ||
          az_be_n !== t_be[1] || m1_waitreq !== 1'b1 || m0_waitreq !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d wr_n=%b addr=%h data=%h be=%b wq1=%b want 0 %h %h %b 1",
                 c, az_wr_n, az_addr, az_data, az_be_n, m1_waitreq, t_addr[1], t_dat[1], t_be[1]);
      end
    end
    n_wait = 1'b0;
    cycle();
    checks++;
    if (acc[1] !== 1'b1 || az_wr_n !== 1'b0 || az_addr !== t_addr[1]) begin
      errors++; $display("FAIL stall_accept: accepted=%b wr_n=%b addr=%h want 1 0 %h", acc[1], az_wr_n, az_addr, t_addr[1]);
    end
    cycle();
    checks++;
    if (az_wr_n !== 1'b1 || m1_waitreq !== 1'b1) begin
      errors++; $display("FAIL stall_release: wr_n=%b wq1=%b want 1 1", az_wr_n, m1_waitreq);
    end
  endtask

  task automatic test_max_pend();
    int n0 = 0, n1 = 0, strobes = 0, fifth_at = -1;
    test_reset();
    for (int i = 0; i < MAX_PEND; i++) begin
      load(1, 1'b0, 1'b0);
      for (int c = 0; c < 10 && act[1]; c++) cycle();
    end
    checks++;
    if (rd_q.size() != MAX_PEND) begin errors++; $display("FAIL mp_fill: got %0d reads accepted want %0d", rd_q.size(), MAX_PEND); end
    load(1, 1'b0, 1'b0);
    load(0, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      cycle();
      n0 += int'(acc[0]);
      n1 += int'(acc[1]);
    end
    checks++;
    if (n0 != 1 || n1 != 0) begin errors++; $display("FAIL mp_stall: got port0=%0d port1=%0d accepts want 1 0", n0, n1); end
    n_zv = 1'b1; n_zd = 16'($urandom);
    for (int c = 0; c < 60 && (act[1] || rd_q.size() > 0 || ret_vld); c++) begin
      cycle();
      if (acc[1] && fifth_at < 0) fifth_at = c;
      if (exp_vld) begin
        strobes++;
        checks++;
        if (exp_port != 1 || m1_valid !== 1'b1 || m0_valid !== 1'b0 || m1_rdata !== exp_dat) begin
          errors++; $display("FAIL mp_return: got v=%b%b m1_rdata=%h want v=01 m1_rdata=%h", m0_valid, m1_valid, m1_rdata, exp_dat);
        end
      end
      if (!act[1] && rd_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        n_zv = 1'b1; n_zd = 16'($urandom);
      end
    end
    checks++;
    if (fifth_at != 2) begin errors++; $display("FAIL mp_fifth: got accept at cycle %0d after return want 2", fifth_at); end
    checks++;
    if (strobes != MAX_PEND + 1) begin errors++; $display("FAIL mp_strobes: got %0d want %0d", strobes, MAX_PEND + 1); end
  endtask

  task automatic test_stray_valid();
    test_reset();
    n_zv = 1'b1; n_zd = 16'h1234;
    cycle();
    cycle();
    checks++;
    if (m0_valid !== 1'b0 || m1_valid !== 1'b0 || m0_rdata !== 16'd0 || m1_rdata !== 16'd0) begin
      errors++; $display("FAIL stray_strobe: v=%b%b rdata=%h/%h want 00 0/0", m0_valid, m1_valid, m0_rdata, m1_rdata);
    end
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL stray_err: proto_err=%b want 1", proto_err); end
    repeat (5) cycle();
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL stray_sticky: proto_err=%b want 1", proto_err); end
  endtask

  task automatic test_abandon();
    test_reset();
    load(0, 1'b0, 1'b0);
    n_wait = 1'b1;
    cycle();
    cycle();
    checks++;
    if (proto_err !== 1'b0 || az_rd_n !== 1'b0) begin
      errors++; $display("FAIL ab_pre: proto_err=%b az_rd_n=%b want 0 0", proto_err, az_rd_n);
    end
    act[0] = 1'b0;
    cycle();
    n_wait = 1'b0;
    cycle();
    checks++;
    if (acc[0] !== 1'b1 || az_rd_n !== 1'b0 || proto_err !== 1'b1) begin
      errors++; $display("FAIL ab_complete: accepted=%b az_rd_n=%b proto_err=%b want 1 0 1", acc[0], az_rd_n, proto_err);
    end
    n_zv = 1'b1; n_zd = 16'hA5C3;
    cycle();
    cycle();
    checks++;
    if (m0_valid !== 1'b1 || m0_rdata !== 16'hA5C3 || m1_valid !== 1'b0) begin
      errors++; $display("FAIL ab_tagged: v=%b%b m0_rdata=%h want 10 a5c3", m0_valid, m1_valid, m0_rdata);
    end
  endtask

  task automatic test_reset_pending();
    test_reset();
    for (int i = 0; i < 2; i++) begin
      load(0, 1'b0, 1'b0);
      for (int c = 0; c < 10 && act[0]; c++) cycle();
    end
    load(1, 1'b1, 1'b0);
    n_wait = 1'b1;
    cycle();
    cycle();
    checks++;
    if (rd_q.size() != 2 || az_wr_n !== 1'b0) begin
      errors++; $display("FAIL rp_setup: reads=%0d az_wr_n=%b want 2 0", rd_q.size(), az_wr_n);
    end
    test_reset();
    n_zv = 1'b1; n_zd = 16'h5555;
    cycle();
    cycle();
    checks++;
    if (m0_valid !== 1'b0 || m1_valid !== 1'b0 || proto_err !== 1'b1) begin
      errors++; $display("FAIL rp_flushed: v=%b%b proto_err=%b want 00 1", m0_valid, m1_valid, proto_err);
    end
  endtask

  task automatic test_random();
    int left[2] = '{40, 40};
    int ld_cyc[2] = '{0, 0};
    logic [15:0] last_rd[2] = '{16'd0, 16'd0};
    int done = 0, last_port = -1, last_cyc = 0;
    bit was_act[2];
    bit ok;
    test_reset();
    for (int c = 0; c < 4000 && (left[0] + left[1] > 0 || act[0] || act[1] || rd_q.size() > 0 || ret_vld); c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && left[p] > 0 && $urandom_range(0, 2) != 0) begin
          load(p, 1'($urandom_range(0, 1)), 1'b0);
          both[p] = wr[p] && ($urandom_range(0, 3) == 0);
          ld_cyc[p] = c;
          left[p]--;
        end
      end
      n_wait = ($urandom_range(0, 3) == 0);
      if (rd_q.size() > 0 && $urandom_range(0, 2) == 0) begin n_zv = 1'b1; n_zd = 16'($urandom); end
      was_act = act;
      cycle();
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          done++;
          checks++;
          if (!was_act[p] || acc[1-p] || az_addr !== t_addr[p] || az_be_n !== t_be[p] || az_data !== t_dat[p] ||
              az_wr_n !== !wr[p] || az_rd_n !== wr[p]) begin
            errors++;
            $display("FAIL rand_cmd: port %0d got addr=%h be=%b data=%h rd_n=%b wr_n=%b want %h %b %h %b %b",
                     p, az_addr, az_be_n, az_data, az_rd_n, az_wr_n, t_addr[p], t_be[p], t_dat[p], wr[p], !wr[p]);
          end
          // A write waiting since the idle cycle after the previous grant must win over a repeat grant.
          if (last_port == p && act[1-p] && wr[1-p] && ld_cyc[1-p] <= last_cyc + 1) begin
            checks++; errors++;
            $display("FAIL rand_fair: port %0d granted twice while port %0d waited", p, 1 - p);
          end
          last_port = p;
          last_cyc = c;
        end
      end
      if (exp_vld) last_rd[exp_port] = exp_dat;
      ok = (m0_valid === (exp_vld && exp_port == 0)) && (m1_valid === (exp_vld && exp_port == 1)) &&
           (m0_rdata === last_rd[0]) && (m1_rdata === last_rd[1]);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_return: got v=%b%b rdata=%h/%h want v=%b%b rdata=%h/%h", m0_valid, m1_valid, m0_rdata, m1_rdata,
                 exp_vld && exp_port == 0, exp_vld && exp_port == 1, last_rd[0], last_rd[1]);
      end
      checks++;
      if (rd_q.size() > MAX_PEND || proto_err !== 1'b0) begin
        errors++; $display("FAIL rand_limits: outstanding=%0d proto_err=%b want <=%0d 0", rd_q.size(), proto_err, MAX_PEND);
      end
    end
    checks++;
    if (done != 80) begin errors++; $display("FAIL rand_complete: got %0d commands want 80", done); end
  endtask

  initial begin
    act = '{default: 1'b0};
    wr = '{default: 1'b0};
    both = '{default: 1'b0};
    t_addr = '{default: 22'd0};
    t_be = '{default: 2'b11};
    t_dat = '{default: 16'd0};
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_stall();
    test_max_pend();
    test_stray_valid();
    test_abandon();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
